// File: rtl/gj_inv_pkg.sv
// Shared types and fixed-point helpers for the Gauss-Jordan matrix inverter.
// Helpers work on a 64-bit signed carrier; callers pass the element width and fraction.
package gj_inv_pkg;

    typedef enum logic [2:0] {
        LOAD,
        SEARCH,
        SWAP,
        RECIP,
        NORM,
        ELIM,
        OUTPUT
    } state_t;

    typedef logic signed [63:0] wide_t;

    localparam int unsigned DEF_FRAC = 8;
    localparam int unsigned ONE      = 1 << DEF_FRAC;

    function automatic int one_fxp(input int unsigned frac);
        return 1 << frac;
    endfunction

    function automatic wide_t sat_dw(input wide_t x, input int unsigned dw);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (dw - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic wide_t rnd_shift(input wide_t x, input int unsigned frac);
        return (x + (wide_t'(1) <<< (frac - 1))) >>> frac;
    endfunction

    // |most negative| has no positive twin, so it clamps to the largest positive value
    function automatic wide_t abs_sat(input wide_t x, input int unsigned dw);
        wide_t lo;
        lo = -(wide_t'(1) <<< (dw - 1));
        if (x == lo) return -lo - wide_t'(1);
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/fxp_seq_divider.sv
// Signed restoring divider, one quotient bit per cycle over ITER low dividend bits.
// Quotient truncates toward zero and saturates to DW bits; the start cycle already computes bit one.
module fxp_seq_divider
    import gj_inv_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned ITER = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient
);
    localparam int unsigned     CNTW     = $clog2(ITER + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(ITER - 1);

    logic [2*DW-1:0] num_abs, num_hi;
    logic [DW-1:0]   den_in, den_abs, src_den;
    logic [DW-1:0]   rem, src_rem, rem_nxt;
    logic [DW:0]     trial;
    logic [ITER-1:0] sh, q, src_q, q_nxt, sh_nxt;
    logic [CNTW-1:0] cnt;
    logic            neg, ovf, src_neg, src_ovf, start_ovf, src_bit, ge, last_step;
    logic [63:0]     q_mag, q_lim;
    logic [DW-1:0]   q_sat;

    always_comb begin
        num_abs   = dividend[2*DW-1] ? -dividend : dividend;
        den_in    = divisor[DW-1] ? -divisor : divisor;
        num_hi    = num_abs >> ITER;
        // Bits above the iterated window must already be below the divisor, else the quotient overflows
        start_ovf = (den_in == '0) || (num_hi >= {{DW{1'b0}}, den_in});
        src_rem   = start ? num_hi[DW-1:0] : rem;
        src_bit   = start ? num_abs[ITER-1] : sh[ITER-1];
        src_q     = start ? '0 : q;
        src_den   = start ? den_in : den_abs;
        src_neg   = start ? (dividend[2*DW-1] ^ divisor[DW-1]) : neg;
        src_ovf   = start ? start_ovf : ovf;
        trial     = {src_rem, src_bit};
        ge        = trial >= {1'b0, src_den};
        rem_nxt   = DW'(ge ? trial - {1'b0, src_den} : trial);
        q_nxt     = {src_q[ITER-2:0], ge};
        sh_nxt    = (start ? num_abs[ITER-1:0] : sh) << 1;
        last_step = start ? (ITER == 1) : (cnt == LAST_CNT);
        q_mag     = 64'(q_nxt);
        q_lim     = src_neg ? (64'd1 << (DW - 1)) : ((64'd1 << (DW - 1)) - 64'd1);
        if (src_ovf || (q_mag > q_lim)) q_mag = q_lim;
        q_sat     = DW'(src_neg ? -q_mag : q_mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            den_abs  <= '0;
            rem      <= '0;
            sh       <= '0;
            q        <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                den_abs <= den_in;
                neg     <= src_neg;
                ovf     <= start_ovf;
                busy    <= 1'b1;
                cnt     <= CNTW'(1);
            end else if (busy) begin
                cnt <= cnt + CNTW'(1);
            end
            if (start || busy) begin
                rem <= rem_nxt;
                q   <= q_nxt;
                sh  <= sh_nxt;
                if (last_step) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    quotient <= q_sat;
                end
            end
        end
    end

endmodule

// File: rtl/gauss_jordan_inverter.sv
// NxN fixed-point matrix inverter: Gauss-Jordan with partial pivoting on [A|I],
// one shared MAC and a sequential divider for the pivot reciprocal.
module gauss_jordan_inverter
    import gj_inv_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          singular,
    output logic          busy
);
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned CW = $clog2(2 * N);

    localparam logic [RW-1:0]        LAST_ROW  = RW'(N - 1);
    localparam logic [RW-1:0]        PREV_ROW  = RW'(N - 2);
    localparam logic [CW-1:0]        LAST_COL  = CW'(2 * N - 1);
    localparam logic [CW-1:0]        HALF_LAST = CW'(N - 1);
    localparam logic [CW-1:0]        HALF      = CW'(N);
    localparam logic signed [DW-1:0] ONE_Q     = DW'(one_fxp(FRAC));
    localparam logic [2*DW-1:0]      RECIP_NUM = {{(2*DW-1){1'b0}}, 1'b1} << (2 * FRAC);

    state_t state, state_nxt;

    logic signed [DW-1:0] m [N][2*N];
    logic [RW-1:0]        k, r, piv_row, cand_row, elim_first, elim_last, i_inc, i_next;
    logic [CW-1:0]        j, colk;
    logic [DW-1:0]        piv_abs, cur_abs, cand_abs;
    logic signed [DW-1:0] recip, f_reg, mac_a, mac_b, mac_out;
    logic signed [2*DW-1:0] prod;
    wide_t                scaled, elim_val;
    logic                 sing_flag, scan_done, cand_take, in_fire, out_fire;
    logic                 div_start, div_busy, div_done;
    logic [DW-1:0]        div_q;

    fxp_seq_divider #(
        .DW   (DW),
        .ITER (DW + FRAC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (RECIP_NUM),
        .divisor  (m[k][colk]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_comb begin
        colk       = CW'(k);
        cur_abs    = DW'(abs_sat(wide_t'(m[r][colk]), DW));
        cand_take  = (r == k) || (cur_abs > piv_abs);
        cand_row   = cand_take ? r : piv_row;
        cand_abs   = cand_take ? cur_abs : piv_abs;
        scan_done  = (r == LAST_ROW);
        elim_first = (k == '0) ? RW'(1) : '0;
        elim_last  = (k == LAST_ROW) ? PREV_ROW : LAST_ROW;
        i_inc      = r + RW'(1);
        i_next     = (i_inc == k) ? r + RW'(2) : i_inc;

        // Column k of row r is overwritten mid-row, so only the j==0 read is the live factor
        if (state == NORM) begin
            mac_a = m[k][j];
            mac_b = recip;
        end else begin
            mac_a = (j == '0) ? m[r][colk] : f_reg;
            mac_b = m[k][j];
        end
        prod     = mac_a * mac_b;
        scaled   = sat_dw(rnd_shift(wide_t'(prod), FRAC), DW);
        elim_val = sat_dw(wide_t'(m[r][j]) - scaled, DW);
        mac_out  = (state == NORM) ? DW'(scaled) : DW'(elim_val);

        in_ready  = (state == LOAD);
        in_fire   = in_valid && in_ready;
        out_valid = (state == OUTPUT);
        out_fire  = out_valid && out_ready;
        out_last  = out_valid && (r == LAST_ROW) && (j == HALF_LAST);
        singular  = out_valid && sing_flag;
        out_data  = (out_valid && !sing_flag) ? m[r][HALF + j] : '0;
        busy      = (state != LOAD) || (r != '0) || (j != '0);
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            LOAD:   if (in_fire && (r == LAST_ROW) && (j == HALF_LAST)) state_nxt = SEARCH;
            SEARCH: if (scan_done) state_nxt = (cand_abs == '0) ? OUTPUT : SWAP;
            SWAP:   state_nxt = RECIP;
            RECIP: begin
                div_start = !div_busy && !div_done;
                if (div_done) state_nxt = NORM;
            end
            NORM:   if (j == LAST_COL) state_nxt = ELIM;
            ELIM: begin
                if ((j == LAST_COL) && (r == elim_last))
                    state_nxt = (k == LAST_ROW) ? OUTPUT : SEARCH;
            end
            OUTPUT: if (out_fire && out_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m         <= '{default: '0};
            k         <= '0;
            r         <= '0;
            j         <= '0;
            piv_row   <= '0;
            piv_abs   <= '0;
            recip     <= '0;
            f_reg     <= '0;
            sing_flag <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_fire) begin
                    m[r][j]        <= in_data;
                    m[r][HALF + j] <= (CW'(r) == j) ? ONE_Q : '0;
                    if (j == HALF_LAST) begin
                        j <= '0;
                        if (r == LAST_ROW) begin
                            r         <= '0;
                            k         <= '0;
                            sing_flag <= 1'b0;
                        end else begin
                            r <= r + RW'(1);
                        end
                    end else begin
                        j <= j + CW'(1);
                    end
                end
                SEARCH: begin
                    piv_row <= cand_row;
                    piv_abs <= cand_abs;
                    if (!scan_done) begin
                        r <= r + RW'(1);
                    end else if (cand_abs == '0) begin
                        sing_flag <= 1'b1;
                        r         <= '0;
                        j         <= '0;
                    end
                end
                SWAP: begin
                    j <= '0;
                    if (piv_row != k) begin
                        for (int unsigned c = 0; c < 2 * N; c++) begin
                            m[k][CW'(c)]       <= m[piv_row][CW'(c)];
                            m[piv_row][CW'(c)] <= m[k][CW'(c)];
                        end
                    end
                end
                RECIP: if (div_done) recip <= div_q;
                NORM: begin
                    m[k][j] <= mac_out;
                    if (j == LAST_COL) begin
                        j <= '0;
                        r <= elim_first;
                    end else begin
                        j <= j + CW'(1);
                    end
                end
                ELIM: begin
                    if (j == '0) f_reg <= m[r][colk];
                    m[r][j] <= mac_out;
                    if (j == LAST_COL) begin
                        j <= '0;
                        if (r == elim_last) begin
                            if (k == LAST_ROW) begin
                                r <= '0;
                            end else begin
                                k <= k + RW'(1);
                                r <= k + RW'(1);
                            end
                        end else begin
                            r <= i_next;
                        end
                    end else begin
                        j <= j + CW'(1);
                    end
                end
                OUTPUT: if (out_fire) begin
                    if (j == HALF_LAST) begin
                        j <= '0;
                        r <= (r == LAST_ROW) ? '0 : r + RW'(1);
                    end else begin
                        j <= j + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
